// File: rtl/modarith_seq_alu_pkg.sv
// Shared definitions for the sequenced modular-arithmetic ALU: opcodes, FSM states,
// instruction field helpers and curve25519 default constants.
package modarith_seq_alu_pkg;

  typedef enum logic [1:0] {
    OpAdd  = 2'd0,
    OpSub  = 2'd1,
    OpMul  = 2'd2,
    OpCneg = 2'd3
  } op_e;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // p = 2^255 - 19 and the twisted Edwards constant d = -121665/121666 mod p
  localparam logic [254:0] DefaultQ =
    255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
  localparam logic [254:0] DefaultCurveD =
    255'h52036cee2b6ffe738cc740797779e89800700a4d4141d8ab75eb4dca135978a3;
  localparam int unsigned DefaultMulLat = 2;

  // Instruction is {op[1:0], dst, src_a, src_b}, each register field ra bits wide.
  function automatic int unsigned ins_width(input int unsigned ra);
    return 2 + 3 * ra;
  endfunction

  function automatic int unsigned dst_lsb(input int unsigned ra);
    return 2 * ra;
  endfunction

  function automatic int unsigned src_a_lsb(input int unsigned ra);
    return ra;
  endfunction

endpackage

// File: rtl/modarith_seq_alu_mul.sv
// Fully pipelined modular multiplier: product reduced in the first stage, then
// delayed so the result appears exactly MUL_LAT cycles after the input is taken.
module mod_mul_pipe
  import modarith_seq_alu_pkg::*;
#(
  parameter int unsigned  W       = 255,
  parameter logic [W-1:0] Q       = W'(DefaultQ),
  parameter int unsigned  MUL_LAT = DefaultMulLat,
  parameter int unsigned  TW      = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [TW-1:0] out_tag
);

  logic [2*W-1:0]     prod;
  logic [2*W-1:0]     q_wide;
  logic [W-1:0]       red;
  logic [MUL_LAT-1:0] valid_q;
  logic [W-1:0]       data_q [MUL_LAT];
  logic [TW-1:0]      tag_q  [MUL_LAT];

  assign prod   = {{W{1'b0}}, in_a} * {{W{1'b0}}, in_b};
  assign q_wide = {{W{1'b0}}, Q};
  assign red    = W'(prod % q_wide);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < MUL_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Payload only moves with its valid bit to avoid needless toggling.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      data_q[0] <= red;
      tag_q[0]  <= in_tag;
    end
    for (int i = 1; i < MUL_LAT; i++) begin
      if (valid_q[i-1]) begin
        data_q[i] <= data_q[i-1];
        tag_q[i]  <= tag_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[MUL_LAT-1];
  assign out_data  = data_q[MUL_LAT-1];
  assign out_tag   = tag_q[MUL_LAT-1];

endmodule

// File: rtl/modarith_seq_alu.sv
// Sequenced modular ALU: runs a short program from local memory against a small
// register file, with in-order single issue and a scoreboard for pipelined MULs.
module modarith_seq_alu
  import modarith_seq_alu_pkg::*;
#(
  parameter int unsigned  W       = 255,
  parameter logic [W-1:0] Q       = W'(DefaultQ),
  parameter int unsigned  NREG    = 8,
  parameter int unsigned  PDEPTH  = 16,
  parameter int unsigned  MUL_LAT = DefaultMulLat,
  localparam int unsigned RA      = $clog2(NREG),
  localparam int unsigned PA      = $clog2(PDEPTH),
  localparam int unsigned IW      = ins_width(RA)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PA-1:0] prog_base,
  input  logic [PA:0]   prog_len,
  input  logic          ins_we,
  input  logic [PA-1:0] ins_addr,
  input  logic [IW-1:0] ins_wdata,
  input  logic          rf_we,
  input  logic [RA-1:0] rf_waddr,
  input  logic [W-1:0]  rf_wdata,
  input  logic [RA-1:0] rf_raddr,
  output logic [W-1:0]  rf_rdata,
  output logic          busy,
  output logic          done,
  output logic          error
);

  logic [1:0]      state_q, state_d;
  logic [PA-1:0]   pc_q;
  logic [PA:0]     left_q;
  logic            error_q;
  logic [W-1:0]    rdata_q;
  logic [NREG-1:0] pend_q, pend_d;

  logic [IW-1:0]   pmem [PDEPTH];
  logic [W-1:0]    rf   [NREG];

  logic [IW-1:0]   ins;
  op_e             op;
  logic [RA-1:0]   dst, src_a, src_b;
  logic [W-1:0]    opa, opb, alu_res;
  logic [W:0]      ax, bx, qx, sum;
  logic            idle, hazard, issue, mul_issue, alu_we, start_ok;
  logic [PA+1:0]   prog_end;
  logic            mul_valid;
  logic [RA-1:0]   mul_tag;
  logic [W-1:0]    mul_data;

  assign idle  = (state_q == StIdle);
  assign ins   = pmem[pc_q];
  assign op    = op_e'(ins[IW-1 -: 2]);
  assign dst   = ins[dst_lsb(RA) +: RA];
  assign src_a = ins[src_a_lsb(RA) +: RA];
  assign src_b = ins[RA-1:0];
  assign opa   = rf[src_a];
  assign opb   = rf[src_b];

  // pend_q stays set through the writeback cycle, so readers see the new value.
  assign hazard    = pend_q[dst] | pend_q[src_a] | pend_q[src_b];
  assign issue     = (state_q == StRun) && !hazard && !(mul_valid && op != OpMul);
  assign mul_issue = issue && (op == OpMul);
  assign alu_we    = issue && (op != OpMul);

  assign prog_end = (PA+2)'(prog_base) + (PA+2)'(prog_len);
  assign start_ok = (prog_len != '0) && (prog_end <= (PA+2)'(PDEPTH));

  assign ax  = {1'b0, opa};
  assign bx  = {1'b0, opb};
  assign qx  = {1'b0, Q};
  assign sum = ax + bx;

  always_comb begin
    alu_res = '0;
    unique case (op)
      OpAdd:   alu_res = (sum >= qx) ? W'(sum - qx) : W'(sum);
      OpSub:   alu_res = (opa >= opb) ? W'(ax - bx) : W'(ax + qx - bx);
      OpCneg:  alu_res = opa[0] ? W'(qx - ax) : opa;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start && start_ok) state_d = StRun;
      StRun:   if (issue && left_q == (PA+1)'(1)) state_d = StDrain;
      StDrain: if (pend_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (mul_valid) pend_d[mul_tag] = 1'b0;
    if (mul_issue) pend_d[dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      left_q  <= '0;
      error_q <= 1'b0;
      pend_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      error_q <= idle && start && !start_ok;
      rdata_q <= rf[rf_raddr];
      if (idle && start) begin
        pc_q   <= prog_base;
        left_q <= prog_len;
      end else if (issue) begin
        pc_q   <= pc_q + 1'b1;
        left_q <= left_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && idle && ins_we) pmem[ins_addr] <= ins_wdata;
  end

  // One write port: MUL writeback, else issuing ALU op, else host (idle only).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (mul_valid) begin
        rf[mul_tag] <= mul_data;
      end else if (alu_we) begin
        rf[dst] <= alu_res;
      end else if (idle && rf_we) begin
        rf[rf_waddr] <= rf_wdata;
      end
    end
  end

  mod_mul_pipe #(
    .W       (W),
    .Q       (Q),
    .MUL_LAT (MUL_LAT),
    .TW      (RA)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (mul_issue),
    .in_a      (opa),
    .in_b      (opb),
    .in_tag    (dst),
    .out_valid (mul_valid),
    .out_data  (mul_data),
    .out_tag   (mul_tag)
  );

  assign busy     = !idle;
  assign done     = (state_q == StDone);
  assign error    = error_q;
  assign rf_rdata = rdata_q;

endmodule

// File: tb/tb_modarith_seq_alu.sv
// Directed bench for modarith_seq_alu (W=8, Q=251): an in-order program model tracks
// the register file and is compared against the host read port every idle cycle.
module tb_modarith_seq_alu;

  localparam int Q = 251;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] prog_base = '0;
  logic [4:0] prog_len = '0;
  logic       ins_we = 1'b0;
  logic [3:0] ins_addr = '0;
  logic [10:0] ins_wdata = '0;
  logic       rf_we = 1'b0;
  logic [2:0] rf_waddr = '0;
  logic [7:0] rf_wdata = '0;
  logic [2:0] rf_raddr = '0;
  logic [7:0] rf_rdata;
  logic       busy, done, error;

  int checks = 0;
  int errors = 0;
  int mrf [8];
  logic [10:0] mprog [16];
  int cur_base = 0, cur_len = 0;
  int done_cnt = 0, err_cnt = 0;
  bit exp_ok = 1'b0;
  int exp_rd = 0;

  modarith_seq_alu #(
    .W       (8),
    .Q       (8'd251),
    .NREG    (8),
    .PDEPTH  (16),
    .MUL_LAT (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prog_base (prog_base),
    .prog_len  (prog_len),
    .ins_we    (ins_we),
    .ins_addr  (ins_addr),
    .ins_wdata (ins_wdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_op(input int op, input int a, input int b);
    if (a < 0 || (op != 3 && b < 0)) return -1;
    case (op)
      0:       return (a + b) % Q;
      1:       return (a - b + Q) % Q;
      2:       return (a * b) % Q;
      default: return (a % 2 == 1) ? Q - a : a;
    endcase
  endfunction

  // Programs execute in order; result equals sequential evaluation.
  function automatic void apply_program();
    for (int i = 0; i < cur_len; i++) begin
      logic [10:0] w;
      w = mprog[cur_base + i];
      mrf[w[8:6]] = model_op(int'(w[10:9]), mrf[w[5:3]], mrf[w[2:0]]);
    end
  endfunction

  always @(negedge clk) begin
    if (exp_ok) chk("rf_rdata", int'(rf_rdata), exp_rd);
    if (done) begin
      chk("done_implies_busy", int'(busy), 1);
      done_cnt++;
      apply_program();
    end
    if (error) begin
      chk("error_implies_idle", int'(busy), 0);
      err_cnt++;
    end
    if (rst) begin
      exp_ok = 1'b1;
      exp_rd = 0;
    end else if (!busy || done) begin
      exp_rd = mrf[rf_raddr];
      exp_ok = (exp_rd >= 0);
    end else begin
      exp_ok = 1'b0;
    end
    if (!rst && !busy && rf_we) mrf[rf_waddr] = int'(rf_wdata);
  end

  task automatic wr(input logic [2:0] r, input logic [7:0] v);
    @(posedge clk); #1;
    rf_we = 1'b1; rf_waddr = r; rf_wdata = v;
    @(posedge clk); #1;
    rf_we = 1'b0;
  endtask

  task automatic iw(input logic [3:0] addr, input logic [1:0] op, input logic [2:0] d,
                    input logic [2:0] a, input logic [2:0] b);
    logic [10:0] w;
    w = {op, d, a, b};
    mprog[addr] = w;
    @(posedge clk); #1;
    ins_we = 1'b1; ins_addr = addr; ins_wdata = w;
    @(posedge clk); #1;
    ins_we = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [2:0] r, input int exp);
    @(posedge clk); #1;
    rf_raddr = r;
    @(negedge clk);
    @(negedge clk);
    chk(name, int'(rf_rdata), exp);
  endtask

  // exp_n: negedges from the start-sampling edge to the one that sees done.
  task automatic run(input int base, input int len, input int exp_n, input bit poke);
    int n, d0, e0;
    bit seen;
    d0 = done_cnt; e0 = err_cnt;
    cur_base = base; cur_len = len;
    @(posedge clk); #1;
    prog_base = 4'(base); prog_len = 5'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = done;
      #1;
      if (poke && n == 1) begin
        start = 1'b1; rf_we = 1'b1; rf_waddr = 3'd0; rf_wdata = 8'd123;
      end
      if (poke && n == 2) begin
        start = 1'b0; rf_we = 1'b0;
      end
    end
    chk("run_done_seen", int'(seen), 1);
    chk("run_latency", n, exp_n);
    @(negedge clk);
    chk("post_done_busy", int'(busy), 0);
    chk("post_done_done", int'(done), 0);
    #1;
    chk("done_pulse_count", done_cnt - d0, 1);
    chk("no_error_on_run", err_cnt - e0, 0);
  endtask

  task automatic rej(input int base, input int len);
    int e0;
    e0 = err_cnt;
    @(posedge clk); #1;
    prog_base = 4'(base); prog_len = 5'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("rej_error_pulse", int'(error), 1);
    chk("rej_busy", int'(busy), 0);
    @(negedge clk);
    chk("rej_error_low", int'(error), 0);
    chk("rej_busy_after", int'(busy), 0);
    #1;
    chk("rej_error_count", err_cnt - e0, 1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mrf[i] = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_rdata", int'(rf_rdata), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADD with wraparound
    wr(3'd0, 8'd0); wr(3'd1, 8'd200); wr(3'd2, 8'd100);
    iw(4'd0, 2'd0, 3'd3, 3'd1, 3'd2);
    run(0, 1, 3, 1'b0);
    rdchk("add_r3", 3'd3, 49);

    // SUB underflow and CNEG odd/even
    wr(3'd1, 8'd3); wr(3'd2, 8'd5);
    iw(4'd1, 2'd1, 3'd3, 3'd1, 3'd2);
    run(1, 1, 3, 1'b0);
    rdchk("sub_r3", 3'd3, 249);
    wr(3'd5, 8'd7);
    iw(4'd2, 2'd3, 3'd4, 3'd5, 3'd0);
    run(2, 1, 3, 1'b0);
    rdchk("cneg_odd_r4", 3'd4, 244);
    wr(3'd5, 8'd8);
    run(2, 1, 3, 1'b0);
    rdchk("cneg_even_r4", 3'd4, 8);

    // RAW on MUL result: ADD stalls two cycles
    wr(3'd1, 8'd16);
    iw(4'd3, 2'd2, 3'd2, 3'd1, 3'd1);
    iw(4'd4, 2'd0, 3'd3, 3'd2, 3'd1);
    run(3, 2, 6, 1'b0);
    rdchk("mul_r2", 3'd2, 5);
    rdchk("raw_add_r3", 3'd3, 21);

    // Write-port conflict: third instruction yields to MUL writeback
    wr(3'd5, 8'd100); wr(3'd6, 8'd200);
    iw(4'd5, 2'd2, 3'd2, 3'd1, 3'd1);
    iw(4'd6, 2'd0, 3'd7, 3'd5, 3'd5);
    iw(4'd7, 2'd0, 3'd4, 3'd5, 3'd6);
    run(5, 3, 6, 1'b0);
    rdchk("conflict_r7", 3'd7, 200);
    rdchk("conflict_r4", 3'd4, 49);
    rdchk("conflict_r2", 3'd2, 5);

    // Back-to-back MULs; start and host write while busy are ignored
    wr(3'd4, 8'd20);
    iw(4'd8, 2'd2, 3'd2, 3'd1, 3'd1);
    iw(4'd9, 2'd2, 3'd3, 3'd4, 3'd4);
    iw(4'd10, 2'd2, 3'd5, 3'd6, 3'd6);
    run(8, 3, 7, 1'b1);
    rdchk("b2b_r3", 3'd3, 149);
    rdchk("b2b_r5", 3'd5, 91);
    rdchk("busy_host_write_ignored", 3'd0, 0);

    // Program ending exactly at the last memory entry
    iw(4'd12, 2'd0, 3'd7, 3'd2, 3'd2);
    iw(4'd13, 2'd1, 3'd6, 3'd0, 3'd7);
    iw(4'd14, 2'd3, 3'd5, 3'd6, 3'd0);
    iw(4'd15, 2'd0, 3'd4, 3'd5, 3'd7);
    run(12, 4, 6, 1'b0);
    rdchk("edge_r6", 3'd6, 241);
    rdchk("edge_r4", 3'd4, 20);

    rej(0, 0);
    rej(12, 5);

    // Reset during DRAIN discards the pending MUL writeback
    wr(3'd6, 8'd77);
    iw(4'd0, 2'd2, 3'd6, 3'd1, 3'd1);
    begin
      int d0;
      d0 = done_cnt;
      cur_base = 0; cur_len = 1;
      @(posedge clk); #1;
      prog_base = 4'd0; prog_len = 5'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy_in_drain", int'(busy), 1);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) begin
        @(negedge clk);
        chk("abort_idle", int'(busy), 0);
        chk("abort_no_done", int'(done), 0);
      end
      #1;
      chk("abort_done_count", done_cnt - d0, 0);
    end
    rdchk("abort_r6_kept", 3'd6, 77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
